// File: rtl/alu_frame_pkg.sv
// Shared definitions for the framed ALU command controller: FSM states,
// reply status codes and the default frame marker.
package alu_frame_pkg;

    typedef enum logic [3:0] {
        HUNT,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        EXEC,
        TX_SYNC,
        TX_STAT,
        TX_RES,
        TX_CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'h01;
    localparam logic [7:0] ST_TO  = 8'h02;
    localparam logic [7:0] ST_OPC = 8'h03;

    // Frame counters stick at 255 rather than wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags expiry on the
// cycle the count sits at TIMEOUT-1. A clear always beats expiry.
module frame_timer #(
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_BITS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_BITS-1:0] cnt_reg;

    assign expire = en && !clr && (cnt_reg == TO_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr || expire) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed command controller: hunts for the sync byte, collects a checksummed
// opcode/operand frame, drives the ALU operand registers and returns a status frame.
module alu_frame_ctrl
    import alu_frame_pkg::*;
#(
    parameter int                  BUS_SIZE  = 8,
    parameter int                  OP_W      = 6,
    parameter logic [BUS_SIZE-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int                  TIMEOUT   = 1_000_000,
    parameter int                  TO_BITS   = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_empty,
    input  logic [BUS_SIZE-1:0] r_data,
    output logic                rd_uart,
    input  logic                tx_full,
    output logic [BUS_SIZE-1:0] w_data,
    output logic                wr_uart,
    output logic [BUS_SIZE-1:0] op_a,
    output logic [BUS_SIZE-1:0] op_b,
    output logic [OP_W-1:0]     op_code,
    input  logic [BUS_SIZE-1:0] alu_result,
    output logic                busy,
    output logic [7:0]          ok_cnt,
    output logic [7:0]          err_cnt
);

    state_t              state_reg, state_next;
    logic [BUS_SIZE-1:0] opc_reg, a_reg, b_reg, chk_reg, res_reg;
    logic [7:0]          stat_reg;
    logic                timer_clr, timer_en, timer_expire;
    logic                opc_bad;

    frame_timer #(
        .TIMEOUT(TIMEOUT),
        .TO_BITS(TO_BITS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .expire(timer_expire)
    );

    assign busy    = (state_reg != HUNT);
    assign opc_bad = (opc_reg[BUS_SIZE-1:OP_W] != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        w_data     = '0;
        timer_en   = 1'b0;
        timer_clr  = 1'b1;
        case (state_reg)
            HUNT: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    if (r_data == SYNC_BYTE) begin
                        state_next = GET_OP;
                    end
                end
            end
            GET_OP, GET_A, GET_B, GET_CHK: begin
                // Timer runs only while a frame is open and the RX FIFO is dry.
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    case (state_reg)
                        GET_OP:  state_next = GET_A;
                        GET_A:   state_next = GET_B;
                        GET_B:   state_next = GET_CHK;
                        default: state_next = EXEC;
                    endcase
                end else begin
                    timer_clr = 1'b0;
                    timer_en  = 1'b1;
                    if (timer_expire) begin
                        state_next = TX_SYNC;
                    end
                end
            end
            EXEC: state_next = TX_SYNC;
            TX_SYNC: begin
                w_data = SYNC_BYTE;
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    state_next = TX_STAT;
                end
            end
            TX_STAT: begin
                w_data = BUS_SIZE'(stat_reg);
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    state_next = TX_RES;
                end
            end
            TX_RES: begin
                w_data = res_reg;
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    state_next = TX_CHK;
                end
            end
            TX_CHK: begin
                w_data = BUS_SIZE'(stat_reg) ^ res_reg;
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opc_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            chk_reg  <= '0;
            res_reg  <= '0;
            stat_reg <= ST_OK;
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= '0;
            ok_cnt   <= '0;
            err_cnt  <= '0;
        end else begin
            if (rd_uart) begin
                case (state_reg)
                    GET_OP: begin
                        opc_reg <= r_data;
                        chk_reg <= r_data;
                    end
                    GET_A: begin
                        a_reg   <= r_data;
                        chk_reg <= chk_reg ^ r_data;
                    end
                    GET_B: begin
                        b_reg   <= r_data;
                        chk_reg <= chk_reg ^ r_data;
                    end
                    GET_CHK: begin
                        // Operands are only committed for a fully valid frame.
                        if (chk_reg != r_data) begin
                            stat_reg <= ST_CHK;
                        end else if (opc_bad) begin
                            stat_reg <= ST_OPC;
                        end else begin
                            stat_reg <= ST_OK;
                            op_a     <= a_reg;
                            op_b     <= b_reg;
                            op_code  <= opc_reg[OP_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (timer_expire) begin
                stat_reg <= ST_TO;
                res_reg  <= '0;
                err_cnt  <= sat_inc(err_cnt);
            end
            if (state_reg == EXEC) begin
                if (stat_reg == ST_OK) begin
                    res_reg <= alu_result;
                    ok_cnt  <= sat_inc(ok_cnt);
                end else begin
                    res_reg <= '0;
                    err_cnt <= sat_inc(err_cnt);
                end
            end
        end
    end

endmodule
